// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder: latches request pulses and presents one pending index (fixed or round-robin).
// Latency: request on x in cycle k is visible on f/y in cycle k+1; y/f are combinational from pend/ptr only.
// Backpressure: a pending index is held until ready is high while f=1; exactly one bit retires per accept.
module priority_encoder_seq #(
    parameter int N  = 8,
    parameter int W  = $clog2(N),
    parameter int RR = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] x,
    input  logic         ready,
    output logic [W-1:0] y,
    output logic         f,
    output logic [N-1:0] pend,
    output logic         ovf
);

    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] clr;
    logic [W-1:0] ptr_q, ptr_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] sel;
    logic         found;
    logic         acc;
    int           idx;

    // Search starts at ptr in round-robin mode, at 0 in fixed mode; wraps at N, not at 2**W.
    always_comb begin
        sel   = '1;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (RR != 0) ? int'(ptr_q) + k : k;
            if (idx >= N) idx = idx - N;
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                sel   = W'(idx);
            end
        end
    end

    assign f    = |pend_q;
    assign y    = sel;
    assign pend = pend_q;
    assign ovf  = ovf_q;
    assign acc  = f & ready;

    // A new request on the bit being retired re-arms it and is not an overflow.
    always_comb begin
        clr    = acc ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;
        pend_d = (pend_q & ~clr) | x;
        ovf_d  = ovf_q | (|(x & pend_q & ~clr));
        ptr_d  = ptr_q;
        if (RR != 0 && acc) begin
            ptr_d = (sel == W'(N - 1)) ? '0 : sel + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            ptr_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ptr_q  <= ptr_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Bench for priority_encoder_seq: three instances (fixed N=8, round-robin N=8, round-robin N=5).
// Expected accepted indices are queued by stimulus and popped by per-instance monitors.
module tb_priority_encoder_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] x_fix = '0, x_rr = '0;
    logic [4:0] x_r5  = '0;
    logic       rdy_fix = 1'b0, rdy_rr = 1'b0, rdy_r5 = 1'b0;
    logic [2:0] y_fix, y_rr, y_r5;
    logic       f_fix, f_rr, f_r5;
    logic [7:0] pend_fix, pend_rr;
    logic [4:0] pend_r5;
    logic       ovf_fix, ovf_rr, ovf_r5;

    int total = 0;
    int bad   = 0;
    int q_fix[$];
    int q_rr[$];
    int q_r5[$];

    priority_encoder_seq #(.N(8), .W(3), .RR(0)) u_fix (
        .clk(clk), .rst(rst), .x(x_fix), .ready(rdy_fix),
        .y(y_fix), .f(f_fix), .pend(pend_fix), .ovf(ovf_fix));

    priority_encoder_seq #(.N(8), .W(3), .RR(1)) u_rr (
        .clk(clk), .rst(rst), .x(x_rr), .ready(rdy_rr),
        .y(y_rr), .f(f_rr), .pend(pend_rr), .ovf(ovf_rr));

    priority_encoder_seq #(.N(5), .W(3), .RR(1)) u_r5 (
        .clk(clk), .rst(rst), .x(x_r5), .ready(rdy_r5),
        .y(y_r5), .f(f_r5), .pend(pend_r5), .ovf(ovf_r5));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Monitors: every accept seen on an instance must match the next queued index.
    always @(negedge clk) begin
        if (!rst && f_fix && rdy_fix) begin
            if (q_fix.size() == 0) chk("fix_unexpected_accept", int'(y_fix), -1);
            else chk("fix_y", int'(y_fix), q_fix.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && f_rr && rdy_rr) begin
            if (q_rr.size() == 0) chk("rr_unexpected_accept", int'(y_rr), -1);
            else chk("rr_y", int'(y_rr), q_rr.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && f_r5 && rdy_r5) begin
            if (q_r5.size() == 0) chk("r5_unexpected_accept", int'(y_r5), -1);
            else chk("r5_y", int'(y_r5), q_r5.pop_front());
        end
    end

    initial begin
        step();
        do_reset();

        chk("rst_f",    int'(f_fix),    0);
        chk("rst_y",    int'(y_fix),    7);
        chk("rst_pend", int'(pend_fix), 0);
        chk("rst_ovf",  int'(ovf_fix),  0);
        chk("rst_rr_y", int'(y_rr),     7);
        chk("rst_r5_y", int'(y_r5),     7);

        // Single request, held until ready.
        x_fix = 8'h04;
        step();
        x_fix = '0;
        chk("single_f",    int'(f_fix),    1);
        chk("single_y",    int'(y_fix),    2);
        chk("single_pend", int'(pend_fix), 8'h04);
        step();
        chk("single_hold_y",    int'(y_fix),    2);
        chk("single_hold_pend", int'(pend_fix), 8'h04);
        q_fix.push_back(2);
        rdy_fix = 1'b1;
        step();
        rdy_fix = 1'b0;
        chk("single_done_f", int'(f_fix), 0);
        chk("single_done_y", int'(y_fix), 7);

        // Fixed priority drain: 1, 4, 7.
        q_fix.push_back(1);
        q_fix.push_back(4);
        q_fix.push_back(7);
        x_fix = 8'b1001_0010;
        step();
        x_fix = '0;
        rdy_fix = 1'b1;
        step();
        chk("fixed_pend_after1", int'(pend_fix), 8'b1001_0000);
        step();
        step();
        chk("fixed_done_f", int'(f_fix), 0);
        chk("fixed_done_y", int'(y_fix), 7);
        step();
        rdy_fix = 1'b0;
        chk("idle_ready_pend", int'(pend_fix), 0);
        chk("idle_ready_ovf",  int'(ovf_fix),  0);

        // Round-robin: 0..7, with bit 0 re-driven during its own accept, served again after 7.
        for (int i = 0; i < 8; i++) q_rr.push_back(i);
        q_rr.push_back(0);
        x_rr = 8'hFF;
        step();
        rdy_rr = 1'b1;
        x_rr   = 8'h01;
        step();
        x_rr = '0;
        chk("rr_rearm_pend", int'(pend_rr), 8'hFF);
        chk("rr_rearm_ovf",  int'(ovf_rr),  0);
        chk("rr_next_y",     int'(y_rr),    1);
        for (int i = 0; i < 8; i++) step();
        rdy_rr = 1'b0;
        chk("rr_done_f",    int'(f_rr),    0);
        chk("rr_done_pend", int'(pend_rr), 0);

        // Overflow: same bit requested twice without an accept.
        x_fix = 8'h01;
        step();
        step();
        x_fix = '0;
        chk("ovf_set", int'(ovf_fix), 1);
        q_fix.push_back(0);
        rdy_fix = 1'b1;
        step();
        rdy_fix = 1'b0;
        chk("ovf_sticky", int'(ovf_fix), 1);
        chk("ovf_pend",   int'(pend_fix), 0);

        // Collision from a fresh reset: set wins, no overflow.
        do_reset();
        chk("coll_rst_ovf", int'(ovf_fix), 0);
        x_fix = 8'h08;
        step();
        q_fix.push_back(3);
        rdy_fix = 1'b1;
        step();
        x_fix = '0;
        rdy_fix = 1'b0;
        chk("coll_pend", int'(pend_fix), 8'h08);
        chk("coll_ovf",  int'(ovf_fix),  0);
        q_fix.push_back(3);
        rdy_fix = 1'b1;
        step();
        rdy_fix = 1'b0;
        chk("coll_drain_f", int'(f_fix), 0);

        // Reset mid-operation discards everything, no partial accept.
        x_rr = 8'hFF;
        step();
        chk("mid_pend_full", int'(pend_rr), 8'hFF);
        rst    = 1'b1;
        rdy_rr = 1'b1;
        step();
        rst    = 1'b0;
        x_rr   = '0;
        rdy_rr = 1'b0;
        chk("mid_rst_pend", int'(pend_rr), 0);
        chk("mid_rst_f",    int'(f_rr),    0);
        chk("mid_rst_y",    int'(y_rr),    7);
        chk("mid_rst_ovf",  int'(ovf_rr),  0);

        // Non-power-of-two wrap (N=5): 0 then 4, ptr 1 then 0.
        q_r5.push_back(0);
        q_r5.push_back(4);
        x_r5 = 5'b10001;
        step();
        x_r5   = '0;
        rdy_r5 = 1'b1;
        step();
        chk("r5_ptr_after0", int'(u_r5.ptr_q), 1);
        step();
        chk("r5_ptr_after4", int'(u_r5.ptr_q), 0);
        chk("r5_done_f",     int'(f_r5),       0);
        chk("r5_done_y",     int'(y_r5),       7);
        rdy_r5 = 1'b0;
        step();

        chk("q_fix_empty", q_fix.size(), 0);
        chk("q_rr_empty",  q_rr.size(),  0);
        chk("q_r5_empty",  q_r5.size(),  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/priority_encoder_seq.md
PRIORITY_ENCODER_SEQ -- requirements
Module: priority_encoder_seq

Interface
REQ-001 Parameter N, default 8, number of request inputs; legal range N >= 2.
REQ-002 Parameter W, default $clog2(N), index width; a value of 3 when N = 8.
REQ-003 Parameter RR, default 0, arbitration mode: 0 = fixed priority, 1 = round-robin.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 x  input  N  request pulses; bit i = request from source i.
REQ-007 ready  input  1  consumer accepts the current index this cycle.
REQ-008 y  output  W  encoded index of the selected pending request.
REQ-009 f  output  1  valid: at least one request is pending.
REQ-010 pend  output  N  current pending-request register.
REQ-011 ovf  output  1  sticky overflow: a request hit an already-pending bit.

Function
REQ-012 Pending update each edge: pend_next = (pend & ~clr) | x, where clr is one-hot at y when f && ready, else zero.
REQ-013 f and y shall be combinational from the registered pend and ptr only, not from x.
REQ-014 Latency: a request on x in cycle k shall give f = 1 in cycle k+1 at the earliest.
REQ-015 f = |pend.
REQ-016 When f = 0, y = all ones ({W{1'b1}}).
REQ-017 Fixed mode (RR = 0): y = lowest set index of pend.
REQ-018 Round-robin mode (RR = 1): y = first set index of pend searching upward from ptr, wrapping from N-1 to 0.
REQ-019 Accept event: f && ready sampled at the rising edge; exactly one bit (index y) is cleared per accept.
REQ-020 ready while f = 0 shall have no effect on any state.
REQ-021 y is not held: while f = 1 and ready = 0, y may change when a higher-priority request becomes pending; an accept always refers to the y shown in that cycle.
REQ-022 ptr: a W-bit register.
  - RR = 1: on each accept of index i, ptr becomes i+1, or 0 when i = N-1. This wrap is correct for non-power-of-two N.
  - ptr is unchanged when there is no accept.
  - RR = 0: ptr stays 0.
REQ-023 Simultaneous x[i] = 1 and accept of i: the set wins, pend[i] = 1 after the edge, and ovf is not set.
REQ-024 ovf is set when x[i] = 1 and pend[i] = 1 and bit i is not cleared in the same cycle. It stays set until rst.
REQ-025 Several x bits may be set in one cycle; all of them are recorded.

Reset
REQ-026 While rst = 1 at an edge, the next state shall be pend = 0, ptr = 0, ovf = 0, and x and ready are ignored.
REQ-027 Output values after reset: f = 0, y = all ones, pend = 0, ovf = 0.
REQ-028 Reset asserted mid-operation shall discard all pending requests with no partial accept.

Verification
REQ-029 Single request: after rst, drive x = 8'h04 for one cycle with ready = 0 -> next cycle f = 1, y = 2, pend = 8'h04. These values hold until ready = 1; one cycle after the accept, f = 0 and y = 3'b111.
REQ-030 Fixed priority: RR = 0, x = 8'b1001_0010 for one cycle, then ready = 1 held -> y sequence is 1, 4, 7, then f = 0 with y = 7.
REQ-031 Round-robin: RR = 1, x = 8'hFF for one cycle, then ready = 1.
  - Serves y = 0, 1, ..., 7 in order.
  - Re-driving x[0] in the cycle bit 0 is accepted leaves pend[0] = 1, and index 0 is next served only after 7.
REQ-032 Overflow and collision:
  - x = 8'h01 on two consecutive cycles with ready = 0 -> ovf = 1 and remains 1.
  - x[3] = 1 in the same cycle bit 3 is accepted -> pend[3] remains 1 and ovf stays 0 from a fresh reset.
REQ-033 Reset mid-operation: with pend = 8'hFF, assert rst for one cycle while x = 8'hFF and ready = 1 -> next cycle pend = 0, f = 0, y = 3'b111, ovf = 0.
REQ-034 Non-power-of-two wrap: N = 5, W = 3, RR = 1, x = 5'b10001, ready = 1 -> y = 0, then 4, then f = 0; ptr goes 1 -> 0 after the accept of index 4.
